// File: rtl/dqoy_frame_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dqoy_frame_rx : serial 6-bit frame receiver into a 2x3 output array,  |
// |                 with optional even parity, abort on restart, counters |
// | Revision      : 1.0                                                   |
// +-----------------------------------------------------------------------+
module dqoy_frame_rx #(
  parameter int PARITY_EN = 1,
  parameter int ERR_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ser_bit,
  input  logic                  ser_sof,
  input  logic                  ser_valid,
  output logic                  ser_ready,
  output logic [3:3][1:0][3:1]  dqoy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic [ERR_W-1:0]      perr_cnt,
  output logic [ERR_W-1:0]      abort_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0]       part_q, part_d;
  logic [5:0]       dqoy_q;
  logic             out_valid_q;
  logic [15:0]      frame_cnt_q;
  logic [ERR_W-1:0] perr_cnt_q;
  logic [ERR_W-1:0] abort_cnt_q;

  logic             w_accept;
  logic [5:0]       w_ins;
  logic [5:0]       w_frame;
  logic             w_done;
  logic             w_perr;
  logic             w_abort;

  assign ser_ready = !out_valid_q || out_ready;
  assign w_accept  = ser_valid && ser_ready;

  // Beat k lands in flat bit 5-k, so beat 0 becomes dqoy[3][1][3].
  always_comb begin
    w_ins = part_q;
    for (int i = 0; i < 6; i++) begin
      if (3'(5 - i) == idx_q) w_ins[i] = ser_bit;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (w_accept) begin
      case (state_q)
        S_IDLE: begin
          if (ser_sof) begin
            state_d = S_RECV;
            idx_d   = 3'd1;
          end
        end
        S_RECV: begin
          if (ser_sof) begin
            idx_d = 3'd1;
          end else if (idx_q == 3'd5) begin
            state_d = (PARITY_EN != 0) ? S_PAR : S_IDLE;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        S_PAR: begin
          if (ser_sof) begin
            state_d = S_RECV;
            idx_d   = 3'd1;
          end else begin
            state_d = S_IDLE;
            idx_d   = 3'd0;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  // Output / event decode
  always_comb begin
    w_done  = 1'b0;
    w_perr  = 1'b0;
    w_abort = 1'b0;
    part_d  = part_q;
    w_frame = (state_q == S_PAR) ? part_q : w_ins;
    if (w_accept) begin
      if (ser_sof) begin
        part_d  = {ser_bit, 5'b0};
        w_abort = (state_q == S_RECV) || (state_q == S_PAR);
      end else if (state_q == S_RECV) begin
        part_d = w_ins;
        w_done = (idx_q == 3'd5) && (PARITY_EN == 0);
      end else if (state_q == S_PAR) begin
        // Even parity: data bits XOR parity bit must be zero.
        w_perr = ^part_q ^ ser_bit;
        w_done = !w_perr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_q      <= 6'd0;
      dqoy_q      <= 6'd0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= 16'd0;
      perr_cnt_q  <= '0;
      abort_cnt_q <= '0;
    end else begin
      part_q <= part_d;
      if (w_done) begin
        dqoy_q      <= w_frame;
        out_valid_q <= 1'b1;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (w_perr && !(&perr_cnt_q)) perr_cnt_q <= perr_cnt_q + 1'b1;
      if (w_abort && !(&abort_cnt_q)) abort_cnt_q <= abort_cnt_q + 1'b1;
    end
  end

  assign dqoy      = dqoy_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_cnt_q;
  assign perr_cnt  = perr_cnt_q;
  assign abort_cnt = abort_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dqoy_frame_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_dqoy_frame_rx : directed bench for dqoy_frame_rx                   |
// | Revision         : 1.0                                                |
// +-----------------------------------------------------------------------+
module tb_dqoy_frame_rx;

  logic                 clk;
  logic                 rst_n;
  logic                 ser_bit;
  logic                 ser_sof;
  logic                 ser_valid;
  logic                 ser_ready;
  logic [3:3][1:0][3:1] dqoy;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic [15:0]          frame_cnt;
  logic [7:0]           perr_cnt;
  logic [7:0]           abort_cnt;

  logic                 ser_ready2;
  logic [3:3][1:0][3:1] dqoy2;
  logic                 out_valid2;
  logic                 busy2;
  logic [15:0]          frame_cnt2;
  logic [1:0]           perr_cnt2;
  logic [1:0]           abort_cnt2;

  int checks   = 0;
  int failures = 0;

  dqoy_frame_rx #(.PARITY_EN(1), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .ser_bit(ser_bit), .ser_sof(ser_sof),
    .ser_valid(ser_valid), .ser_ready(ser_ready), .dqoy(dqoy),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .frame_cnt(frame_cnt), .perr_cnt(perr_cnt), .abort_cnt(abort_cnt)
  );

  dqoy_frame_rx #(.PARITY_EN(1), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ser_bit(ser_bit), .ser_sof(ser_sof),
    .ser_valid(ser_valid), .ser_ready(ser_ready2), .dqoy(dqoy2),
    .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2),
    .frame_cnt(frame_cnt2), .perr_cnt(perr_cnt2), .abort_cnt(abort_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Offer one beat, wait (bounded) for ready, complete on the next edge.
  task automatic beat(input logic b, input logic s);
    int n;
    n = 0;
    ser_bit   = b;
    ser_sof   = s;
    ser_valid = 1'b1;
    while (!ser_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    @(posedge clk);
    #1;
    ser_valid = 1'b0;
    ser_sof   = 1'b0;
  endtask

  task automatic frame(input logic [5:0] d, input logic p);
    beat(d[5], 1'b1);
    for (int i = 4; i >= 0; i--) beat(d[i], 1'b0);
    beat(p, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    ser_bit   = 1'b0;
    ser_sof   = 1'b0;
    ser_valid = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dqoy", dqoy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_perr", perr_cnt, 0);
    chk("rst_abort", abort_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ser_ready", ser_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good frame 101110, parity 0
    beat(1'b0, 1'b0);
    chk("idle_discard_busy", busy, 0);
    beat(1'b1, 1'b1);
    chk("recv_busy", busy, 1);
    for (int i = 4; i >= 0; i--) beat(6'b101110 >> i, 1'b0);
    chk("pre_par_out_valid", out_valid, 0);
    beat(1'b0, 1'b0);
    chk("s1_out_valid", out_valid, 1);
    chk("s1_dqoy", dqoy, 6'b101110);
    chk("s1_dqoy_corner", dqoy[3][1][3], 1);
    chk("s1_frame_cnt", frame_cnt, 1);
    chk("s1_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("s1_consumed", out_valid, 0);

    // Same frame, bad parity
    frame(6'b101110, 1'b1);
    chk("s2_out_valid", out_valid, 0);
    chk("s2_perr", perr_cnt, 1);
    chk("s2_busy", busy, 0);
    chk("s2_frame_cnt", frame_cnt, 1);
    chk("s2_dqoy_hold", dqoy, 6'b101110);

    // Abort at beat 3, then frame 010011 (odd data, parity 1)
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    chk("s3_abort", abort_cnt, 1);
    chk("s3_no_partial", dqoy, 6'b101110);
    for (int i = 4; i >= 0; i--) beat(6'b010011 >> i, 1'b0);
    beat(1'b1, 1'b0);
    chk("s3_out_valid", out_valid, 1);
    chk("s3_dqoy", dqoy, 6'b010011);
    chk("s3_frame_cnt", frame_cnt, 2);
    chk("s3_abort_after", abort_cnt, 1);
    @(posedge clk);
    #1;

    // Backpressure: A held, B stalls until a one-cycle out_ready pulse
    out_ready = 1'b0;
    frame(6'b110000, 1'b0);
    chk("s4_a_valid", out_valid, 1);
    chk("s4_a_dqoy", dqoy, 6'b110000);
    chk("s4_ready_low", ser_ready, 0);
    fork
      frame(6'b001101, 1'b1);
      begin
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("s4_a_held", dqoy, 6'b110000);
        chk("s4_a_valid_held", out_valid, 1);
        chk("s4_busy_stalled", busy, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("s4_a_consumed", out_valid, 0);
      end
    join
    chk("s4_b_valid", out_valid, 1);
    chk("s4_b_dqoy", dqoy, 6'b001101);
    chk("s4_frame_cnt", frame_cnt, 4);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("s4_b_consumed", out_valid, 0);

    // Reset mid-frame
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_frame", frame_cnt, 0);
    chk("s5_rst_perr", perr_cnt, 0);
    chk("s5_rst_abort", abort_cnt, 0);
    chk("s5_rst_dqoy", dqoy, 0);
    chk("s5_rst_ready", ser_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(1'b1, 1'b0);
    chk("s5_discard_busy", busy, 0);
    chk("s5_frame_pre", frame_cnt, 0);
    frame(6'b101110, 1'b0);
    chk("s5_frame_cnt", frame_cnt, 1);
    chk("s5_abort", abort_cnt, 0);
    chk("s5_dqoy", dqoy, 6'b101110);
    @(posedge clk);
    #1;

    // Five parity errors: 8-bit counter counts, 2-bit counter saturates
    for (int k = 0; k < 5; k++) begin
      logic [5:0] d;
      d = 6'(k * 7 + 3);
      frame(d, ~(^d));
      if (k == 1) chk("s6_perr2_two", perr_cnt2, 2);
    end
    chk("s6_perr", perr_cnt, 5);
    chk("s6_perr2_sat", perr_cnt2, 3);
    chk("s6_frame_cnt", frame_cnt, 1);
    chk("s6_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dqoy_frame_rx.md
DQOY_FRAME_RX -- requirements
Module: dqoy_frame_rx

Interface
REQ-001 Parameter: PARITY_EN, default 1, meaning a trailing even-parity bit follows every frame (0 = no parity beat).
REQ-002 Parameter: ERR_W, default 8, meaning the width of each saturating error counter.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: ser_bit  input  1  serial data bit.
REQ-007 Port: ser_sof  input  1  marks the first bit of a frame; qualified by ser_valid.
REQ-008 Port: ser_valid  input  1  the beat is offered.
REQ-009 Port: ser_ready  output  1  the beat is accepted when ser_valid && ser_ready.
REQ-010 Port: dqoy  output  bit [3:3] [1:0][3:1]  the assembled 2x3 frame.
REQ-011 Port: out_valid  output  1  dqoy holds an undelivered frame.
REQ-012 Port: out_ready  input  1  the sink consumes dqoy when out_valid && out_ready.
REQ-013 Port: busy  output  1  the FSM is not in IDLE.
REQ-014 Port: frame_cnt  output  16  count of good frames delivered into dqoy; wraps at 2^16.
REQ-015 Port: perr_cnt  output  ERR_W  count of parity failures; saturates at all-ones.
REQ-016 Port: abort_cnt  output  ERR_W  count of frames restarted by a mid-frame ser_sof; saturates at all-ones.

Function
REQ-017 ser_ready SHALL equal (!out_valid || out_ready), combinationally; no beat is ever dropped for lack of space.
REQ-018 Bit order SHALL be: data beats 0..5 map to dqoy[1][3], [1][2], [1][1], [0][3], [0][2], [0][1]; then the parity beat when PARITY_EN=1.
REQ-019 The FSM SHALL have three states: IDLE, RECV and PAR, with a 3-bit beat index idx.
REQ-020 IDLE: an accepted beat with ser_sof=1 SHALL store bit 0, set idx=1 and go to RECV; accepted beats with ser_sof=0 are discarded.
REQ-021 RECV: an accepted beat with ser_sof=0 SHALL store bit idx and increment idx; after bit 5 the FSM goes to PAR (PARITY_EN=1) or completes the frame (PARITY_EN=0).
REQ-022 RECV or PAR with an accepted ser_sof=1 beat: abort_cnt++, the partial frame is discarded, the beat is taken as the new bit 0, idx=1, and the state is RECV.
REQ-023 PAR: the accepted beat SHALL be the parity bit; XOR of the 6 data bits and the parity bit == 0 means good, and 1 means perr_cnt++ with the frame discarded; the FSM then goes to IDLE.
REQ-024 Completion of a good frame SHALL load dqoy, set out_valid=1 and increment frame_cnt on the clock edge that accepts the final beat; latency from the final beat is 1 cycle.
REQ-025 PARITY_EN=0: the FSM returns to IDLE after bit 5.
REQ-026 out_valid SHALL clear on a handshake unless a new frame completes in the same cycle, in which case dqoy reloads and out_valid stays 1.
REQ-027 dqoy SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 The data register SHALL update only on frame completion; partial frames are never visible on dqoy.
REQ-029 Counters SHALL saturate at the limits given for each port; simultaneous events are impossible because each beat causes at most one event.

Reset
REQ-030 rst_n low SHALL immediately force: state=IDLE, idx=0, dqoy=0, out_valid=0, all counters=0.
REQ-031 Reset mid-frame SHALL discard the partial frame with no counter change afterward; the first accepted beat after release is handled per IDLE rules.
REQ-032 ser_ready SHALL be 1 during and after reset, because out_valid=0.

Verification
REQ-033 Scenario: PARITY_EN=1; beats 1(sof),0,1,1,1,0, parity 0 -> next cycle out_valid=1, {dqoy[1],dqoy[0]}=6'b101110, frame_cnt=1.
REQ-034 Scenario: the same frame with parity 1 -> out_valid stays 0, perr_cnt=1, busy=0.
REQ-035 Scenario: sof at beat 3 of a frame, then 6 data beats plus good parity -> abort_cnt=1, only the second frame is delivered, frame_cnt=1.
REQ-036 Scenario: out_ready=0 while frame A is held, then frame B is streamed -> ser_ready=0 stalls B; when out_ready pulses, A is consumed, B completes, both are delivered in order, frame_cnt=2.
REQ-037 Scenario: rst_n asserted after 3 beats, then a full good frame -> counters stay 0 until the frame completes, then frame_cnt=1; ERR_W=2 with 5 parity errors -> perr_cnt=3.
